// File: rtl/heat_cool_scheduler.sv
// heat_cool_scheduler
//
// Thermostat sequencer. It produces the heat request (A) and the cool request (B)
// for the downstream heating/cooling controller. It compares the temperature
// sample against setpoint +/- hysteresis. Every run lasts at least MIN_ON cycles
// unless enable drops. Every run is followed by a LOCKOUT interval of exactly
// LOCKOUT cycles, so there is never a direct heat<->cool switch.
//
// Optional feature macro: HEAT_COOL_STATS_EN (adds run counters and stats_clr).
//
// Ports:
//   clock      in   system clock, rising edge
//   rst        in   synchronous active-low reset
//   en         in   scheduler enable
//   temp       in   [TW]  temperature sample
//   setpoint   in   [TW]  target temperature
//   hyst       in   [TW]  hysteresis half-band
//   heat_req   out  registered heat request (HEAT only)
//   cool_req   out  registered cool request (COOL only)
//   state_o    out  [2]   00 IDLE, 01 HEAT, 10 COOL, 11 LOCKOUT
//   lockout_o  out  high while in LOCKOUT
//   stats_clr  in   (HEAT_COOL_STATS_EN) clear run counters, wins over increment
//   heat_runs  out  [8] (HEAT_COOL_STATS_EN) saturating IDLE->HEAT count
//   cool_runs  out  [8] (HEAT_COOL_STATS_EN) saturating IDLE->COOL count

module heat_cool_scheduler #(
    parameter int unsigned TW      = 8,
    parameter int unsigned MIN_ON  = 16,
    parameter int unsigned LOCKOUT = 32,
    parameter int unsigned CW      = 6
) (
    input  logic          clock,
    input  logic          rst,
    input  logic          en,
    input  logic [TW-1:0] temp,
    input  logic [TW-1:0] setpoint,
    input  logic [TW-1:0] hyst,
`ifdef HEAT_COOL_STATS_EN
    input  logic          stats_clr,
    output logic [7:0]    heat_runs,
    output logic [7:0]    cool_runs,
`endif
    output logic          heat_req,
    output logic          cool_req,
    output logic [1:0]    state_o,
    output logic          lockout_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_HEAT = 2'b01,
        S_COOL = 2'b10,
        S_LOCK = 2'b11
    } state_t;

    localparam logic [CW-1:0] MIN_ON_LAST  = CW'(MIN_ON - 1);
    localparam logic [CW-1:0] LOCKOUT_LAST = CW'(LOCKOUT - 1);

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic          r_heat_req;
    logic          r_cool_req;
    logic          r_lockout;

    logic [TW:0]   w_sum;
    logic [TW:0]   w_low;
    logic [TW:0]   w_high;
    logic [TW:0]   w_temp_x;
    logic          w_min_done;

    // Thresholds use one extra bit. The sum carry selects the top clamp. The
    // setpoint/hyst compare selects the bottom clamp. This keeps low <= high.
    always_comb begin
        w_sum    = {1'b0, setpoint} + {1'b0, hyst};
        w_temp_x = {1'b0, temp};
        w_low    = (setpoint >= hyst) ? {1'b0, setpoint - hyst} : '0;
        w_high   = w_sum[TW] ? {1'b0, {TW{1'b1}}} : w_sum;
    end

    assign w_min_done = (r_cnt >= MIN_ON_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (en && (w_temp_x < w_low)) begin
                    w_next = S_HEAT;
                end else if (en && (w_temp_x > w_high)) begin
                    w_next = S_COOL;
                end
            end
            S_HEAT: begin
                if (!en || (w_min_done && (temp >= setpoint))) begin
                    w_next = S_LOCK;
                end
            end
            S_COOL: begin
                if (!en || (w_min_done && (temp <= setpoint))) begin
                    w_next = S_LOCK;
                end
            end
            S_LOCK: begin
                if (r_cnt == LOCKOUT_LAST) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // The outputs are decoded from the next state, so they switch on the same
    // edge as the state register.
    always_ff @(posedge clock) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_heat_req <= 1'b0;
            r_cool_req <= 1'b0;
            r_lockout  <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_heat_req <= (w_next == S_HEAT);
            r_cool_req <= (w_next == S_COOL);
            r_lockout  <= (w_next == S_LOCK);
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (r_cnt != '1) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign heat_req  = r_heat_req;
    assign cool_req  = r_cool_req;
    assign lockout_o = r_lockout;
    assign state_o   = r_state;

`ifdef HEAT_COOL_STATS_EN
    logic [7:0] r_heat_runs;
    logic [7:0] r_cool_runs;
    logic       w_heat_entry;
    logic       w_cool_entry;

    assign w_heat_entry = (r_state == S_IDLE) && (w_next == S_HEAT);
    assign w_cool_entry = (r_state == S_IDLE) && (w_next == S_COOL);

    always_ff @(posedge clock) begin
        if (!rst || stats_clr) begin
            r_heat_runs <= '0;
            r_cool_runs <= '0;
        end else begin
            if (w_heat_entry && (r_heat_runs != '1)) begin
                r_heat_runs <= r_heat_runs + 1'b1;
            end
            if (w_cool_entry && (r_cool_runs != '1)) begin
                r_cool_runs <= r_cool_runs + 1'b1;
            end
        end
    end

    assign heat_runs = r_heat_runs;
    assign cool_runs = r_cool_runs;
`endif

endmodule

// File: doc/heat_cool_scheduler.md
Name: heat_cool_scheduler

Overview:
- Thermostat sequencer that drives the heat request (A) and cool request (B) inputs of the heating/cooling state machine.
- Compares a sampled temperature against a setpoint with hysteresis.
- Enforces a minimum run time per mode and a lockout interval after every run, so the heater and cooler never chatter or switch directly into each other.
- Sits between the temperature sensor interface and the heating/cooling controller.

Parameters:
- TW, 8: width of temp, setpoint and hyst (unsigned).
- MIN_ON, 16: minimum cycles in HEAT or COOL before a temperature-driven exit; must be >= 1.
- LOCKOUT, 32: cycles spent in LOCKOUT after any HEAT/COOL run; must be >= 1.
- CW, 6: dwell counter width; must satisfy 2^CW > max(MIN_ON, LOCKOUT).

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-low reset.
- en  input  1  scheduler enable.
- temp  input  TW  current temperature sample.
- setpoint  input  TW  target temperature.
- hyst  input  TW  hysteresis half-band.
- heat_req  output  1  drives A of the heating/cooling controller.
- cool_req  output  1  drives B of the heating/cooling controller.
- state_o  output  2  current state: 00 IDLE, 01 HEAT, 10 COOL, 11 LOCKOUT.
- lockout_o  output  1  high while in LOCKOUT.

Behaviour:
- Reset (rst=0 at a clock edge): state IDLE, dwell counter 0, heat_req=0, cool_req=0, lockout_o=0, state_o=00.
  - Reset mid-run returns to IDLE immediately; no lockout is served.
- Thresholds, computed combinationally in TW+1 bits:
  - low = setpoint - hyst, clamped at 0.
  - high = setpoint + hyst, clamped at 2^TW-1.
  - low <= high always holds, so the heat and cool entry conditions are mutually exclusive.
- Dwell counter:
  - Cleared to 0 on every state change.
  - Otherwise increments each cycle and saturates at 2^CW-1.
- IDLE:
  - en=1 and temp < low -> HEAT.
  - Else en=1 and temp > high -> COOL.
  - Else stay in IDLE.
  - temp == low or temp == high does not trigger entry.
- HEAT:
  - en=0 -> LOCKOUT next edge (safety override; ignores MIN_ON).
  - Else cnt >= MIN_ON-1 and temp >= setpoint -> LOCKOUT.
  - Else stay in HEAT.
- COOL:
  - en=0 -> LOCKOUT.
  - Else cnt >= MIN_ON-1 and temp <= setpoint -> LOCKOUT.
  - Else stay in COOL.
- LOCKOUT:
  - en and temp are ignored.
  - cnt == LOCKOUT-1 -> IDLE.
  - Total dwell is exactly LOCKOUT cycles.
- There is no direct HEAT<->COOL transition; every run passes through LOCKOUT.
- Outputs:
  - All outputs are registered and updated on the same edge as the state register.
  - heat_req=1 only in HEAT; cool_req=1 only in COOL.
  - heat_req and cool_req are never both 1.
- Latency: an entry condition present before edge N gives a request asserted after edge N (1 cycle).
- Input changes during LOCKOUT have no effect until IDLE has been entered.
- Unused or illegal state encodings recover to IDLE on the next edge.

Optional Feature:
- Macro: HEAT_COOL_STATS_EN.
- When defined, add output ports:
  - heat_runs (8 bits): saturating count of IDLE->HEAT entries.
  - cool_runs (8 bits): saturating count of IDLE->COOL entries.
  - stats_clr (input, 1 bit): synchronous clear of both counts; has priority over increment in the same cycle.
  - Both counts reset to 0 on rst=0.
- When not defined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Heat entry and min-on: rst released, en=1, setpoint=100, hyst=5, temp=94; temp set to 100 on cycle 3.
  - Required: heat_req=1 one cycle after entry; it stays 1 until 16 cycles elapse, then LOCKOUT; lockout_o=1 for 32 cycles; then IDLE.
- Cool entry at boundary: setpoint=100, hyst=5.
  - temp=105: no entry.
  - temp=106: cool_req=1 next cycle.
  - temp then drops to 100 after MIN_ON: LOCKOUT.
- Saturation: setpoint=3, hyst=10, temp=0.
  - Required: low clamps to 0, so no heat entry.
  - setpoint=250, hyst=10, temp=255: high clamps to 255, so no cool entry.
- Enable drop: in HEAT at cnt=4, en=0.
  - Required: LOCKOUT next edge, heat_req=0.
  - With temp=50 and en=1 held during LOCKOUT: HEAT is re-entered only after 32 lockout cycles plus one IDLE cycle.
- Reset mid-operation: rst=0 for one edge during COOL.
  - Required: state_o=00, cool_req=0 and lockout_o=0 immediately.
  - Heat entry is allowed on the next edge after rst returns to 1.
- Stats (HEAT_COOL_STATS_EN): run 3 heat cycles and 2 cool cycles.
  - Required: heat_runs=3, cool_runs=2.
  - stats_clr=1 coinciding with an IDLE->HEAT entry leaves heat_runs=0.
